// File: rtl/instruction_fetch.sv
// Instruction fetch initiator: issues word-aligned fetch requests against a credit limit,
// buffers in-order responses tagged with their PC, and handles redirects and stale drops.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        fetch_misaligned
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_entry_t;

  if_entry_t       q_mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   out_cnt, drop_cnt, q_cnt;
  logic [31:0]     pc_q, rsp_pc_q;
  logic            mis_q;
  logic            accept, push, pop;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    imem_req_valid   = !rst && !mis_q && !redirect_valid &&
                       (({1'b0, out_cnt} + {1'b0, q_cnt}) < (CW+1)'(DEPTH));
    imem_addr        = pc_q;
    if_valid         = !rst && (q_cnt != '0);
    if_instr         = q_mem[head].instr;
    if_pc            = q_mem[head].pc;
    fetch_misaligned = mis_q;
    accept           = imem_req_valid && imem_req_ready;
    push             = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    pop              = if_valid && id_ready && !redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
      q_cnt    <= '0;
      head     <= '0;
      tail     <= '0;
      mis_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
    end else begin
      out_cnt <= out_cnt + CW'(accept) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        // Outstanding already includes requests marked for dropping, so every request
        // still in flight after this cycle becomes stale: no double counting.
        drop_cnt <= out_cnt - CW'(imem_rsp_valid);
        q_cnt    <= '0;
        head     <= '0;
        tail     <= '0;
        pc_q     <= redirect_pc;
        rsp_pc_q <= redirect_pc;
        mis_q    <= |redirect_pc[1:0];
      end else begin
        if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
        if (push) begin
          q_mem[tail] <= '{pc: rsp_pc_q, instr: imem_rsp_data};
          tail        <= ptr_nxt(tail);
          rsp_pc_q    <= rsp_pc_q + 32'd4;
        end
        if (pop) head <= ptr_nxt(head);
        q_cnt <= q_cnt + CW'(push) - CW'(pop);
        if (accept) pc_q <= pc_q + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a behavioural memory answers accepted requests,
// expected {pc, instr} pairs are queued at accept time and checked when decode pops them.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        id_ready;
  logic        fetch_misaligned;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .fetch_misaligned(fetch_misaligned)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  int          n_cmp = 0, n_bad = 0;
  int          cycle = 0, lat = 1;
  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  logic [31:0] acc_log[$], pop_log[$];
  logic [31:0] mpc;
  bit          mmis;
  int          m_out, m_qc, m_drop;
  bit          s_req_valid, s_acc;
  logic [31:0] s_addr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  // One clock: check outputs against the model, advance the model, drive the next response.
  task automatic cyc();
    bit exp_rv, acc, rsp, pop;
    #1;
    exp_rv = !mmis && !redirect_valid && (m_out + m_qc) < 2;
    n_cmp++;
    if (imem_req_valid !== exp_rv) begin
      n_bad++; $display("FAIL req_valid @%0d: got %b want %b", cycle, imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      n_cmp++;
      if (imem_addr !== mpc) begin
        n_bad++; $display("FAIL imem_addr @%0d: got %h want %h", cycle, imem_addr, mpc);
      end
    end
    n_cmp++;
    if (if_valid !== (m_qc != 0)) begin
      n_bad++; $display("FAIL if_valid @%0d: got %b want %b", cycle, if_valid, m_qc != 0);
    end
    if (if_valid === 1'b1 && m_qc != 0) begin
      n_cmp++;
      if (if_pc !== exp_q[0].pc || if_instr !== exp_q[0].instr) begin
        n_bad++; $display("FAIL head @%0d: got pc %h instr %h want pc %h instr %h",
                          cycle, if_pc, if_instr, exp_q[0].pc, exp_q[0].instr);
      end
    end
    n_cmp++;
    if (fetch_misaligned !== mmis) begin
      n_bad++; $display("FAIL misaligned @%0d: got %b want %b", cycle, fetch_misaligned, mmis);
    end
    acc = (imem_req_valid === 1'b1) && imem_req_ready;
    rsp = imem_rsp_valid;
    pop = (m_qc != 0) && id_ready && !redirect_valid;
    if (rsp && m_out == 0) begin
      n_cmp++; n_bad++; $display("FAIL rsp_no_outstanding @%0d: got 1 want 0", cycle);
    end
    s_req_valid = imem_req_valid; s_addr = imem_addr; s_acc = acc;
    if (redirect_valid) begin
      m_drop = m_out - int'(rsp);
      m_qc   = 0;
      exp_q.delete();
      mpc    = redirect_pc;
      mmis   = redirect_pc[1:0] != 2'b00;
    end else begin
      if (rsp) begin
        if (m_drop > 0) m_drop--; else m_qc++;
      end
      if (pop) begin
        pop_log.push_back(exp_q[0].pc);
        void'(exp_q.pop_front());
        m_qc--;
      end
      if (acc) begin
        acc_log.push_back(imem_addr);
        exp_q.push_back('{mpc, memfn(mpc)});
        mem_q.push_back('{imem_addr, cycle + lat});
        mpc = mpc + 32'd4;
      end
    end
    m_out = m_out + int'(acc) - int'(rsp);
    @(posedge clk); cycle++;
    @(negedge clk);
    if (mem_q.size() > 0 && mem_q[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    cyc();
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; id_ready = 1'b1;
    mem_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
        n_bad++; $display("FAIL reset_valids: got req %b if %b want 0 0", imem_req_valid, if_valid);
      end
      if (i > 0) begin
        n_cmp++;
        if (fetch_misaligned !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
          n_bad++; $display("FAIL reset_state: got mis %b pc %h instr %h want 0 0 0",
                            fetch_misaligned, if_pc, if_instr);
        end
      end
      @(posedge clk); cycle++; @(negedge clk);
    end
    rst = 1'b0;
    mpc = 32'h0; mmis = 0; m_out = 0; m_qc = 0; m_drop = 0; lat = 1;
    acc_log.delete(); pop_log.delete();
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 20 && pop_log.size() < 3; i++) cyc();
    n_cmp++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8) begin
      n_bad++; $display("FAIL reset_accepts: got %0d accepts want 0,4,8 first", acc_log.size());
    end
    n_cmp++;
    if (pop_log.size() < 3 || pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8) begin
      n_bad++; $display("FAIL reset_pops: got %0d pops want pcs 0,4,8", pop_log.size());
    end
  endtask

  task automatic test_decode_stall();
    do_reset();
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (if_valid === 1'b1) begin
        n_cmp++;
        if (if_pc !== 32'h0) begin
          n_bad++; $display("FAIL stall_head: got %h want 00000000", if_pc);
        end
      end
    end
    n_cmp++;
    if (acc_log.size() != 2) begin
      n_bad++; $display("FAIL stall_credit: got %0d accepts want 2", acc_log.size());
    end
    id_ready = 1'b1;
    for (int i = 0; i < 40 && pop_log.size() < 6; i++) cyc();
    n_cmp++;
    if (pop_log.size() < 6) begin
      n_bad++; $display("FAIL stall_drain: got %0d pops want 6", pop_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (pop_log[i] !== 32'(4 * i)) begin
          n_bad++; $display("FAIL stall_order[%0d]: got %h want %h", i, pop_log[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    lat = 3;
    for (int i = 0; i < 30 && !(mpc == 32'h10 && m_out == 2); i++) cyc();
    n_cmp++;
    if (!(mpc == 32'h10 && m_out == 2)) begin
      n_bad++; $display("FAIL inflight_setup: got next pc %h outstanding %0d want 10 2", mpc, m_out);
    end
    redirect(32'h40);
    n_cmp++;
    if (s_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL redirect_noreq: got %b want 0", s_req_valid);
    end
    lat = 1; pop_log.delete();
    for (int i = 0; i < 30 && pop_log.size() < 1; i++) cyc();
    n_cmp++;
    if (pop_log.size() < 1 || pop_log[0] !== 32'h40) begin
      n_bad++; $display("FAIL redirect_target: got %0d pops want first pc 40", pop_log.size());
    end
  endtask

  task automatic test_misaligned();
    redirect(32'h42);
    n_cmp++;
    if (fetch_misaligned !== 1'b1) begin
      n_bad++; $display("FAIL mis_set: got %b want 1", fetch_misaligned);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++;
      if (s_req_valid !== 1'b0) begin
        n_bad++; $display("FAIL mis_noreq: got %b want 0", s_req_valid);
      end
    end
    redirect(32'h80);
    n_cmp++;
    if (fetch_misaligned !== 1'b0) begin
      n_bad++; $display("FAIL mis_clear: got %b want 0", fetch_misaligned);
    end
    acc_log.delete();
    for (int i = 0; i < 10 && acc_log.size() < 1; i++) cyc();
    n_cmp++;
    if (acc_log.size() < 1 || acc_log[0] !== 32'h80) begin
      n_bad++; $display("FAIL mis_resume: got %0d accepts want first 80", acc_log.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] saved;
    redirect(32'h100);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 10 && imem_req_valid !== 1'b1; i++) cyc();
    saved = imem_addr;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (s_req_valid !== 1'b1 || s_addr !== saved) begin
        n_bad++; $display("FAIL bp_hold: got valid %b addr %h want 1 %h", s_req_valid, s_addr, saved);
      end
    end
    acc_log.delete();
    imem_req_ready = 1'b1;
    cyc();
    n_cmp++;
    if (acc_log.size() != 1 || acc_log[0] !== saved) begin
      n_bad++; $display("FAIL bp_accept: got %0d accepts want 1 at %h", acc_log.size(), saved);
    end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    acc_log.delete(); pop_log.delete();
    for (int i = 0; i < 30 && pop_log.size() < 2; i++) cyc();
    n_cmp++;
    if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC || acc_log[1] !== 32'h0) begin
      n_bad++; $display("FAIL wrap_addr: got %0d accepts want fffffffc,00000000", acc_log.size());
    end
    n_cmp++;
    if (pop_log.size() < 2 || pop_log[0] !== 32'hFFFF_FFFC || pop_log[1] !== 32'h0) begin
      n_bad++; $display("FAIL wrap_pc: got %0d pops want fffffffc,00000000", pop_log.size());
    end
  endtask

  task automatic test_back_to_back();
    lat = 2;
    for (int i = 0; i < 4; i++) cyc();
    redirect(32'h200);
    redirect(32'h300);
    pop_log.delete();
    for (int i = 0; i < 30 && pop_log.size() < 2; i++) cyc();
    n_cmp++;
    if (pop_log.size() < 2 || pop_log[0] !== 32'h300 || pop_log[1] !== 32'h304) begin
      n_bad++; $display("FAIL b2b_redirect: got %0d pops want 300,304", pop_log.size());
    end
    lat = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      id_ready       = ($urandom_range(0, 9) < 7);
      imem_req_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) lat = $urandom_range(1, 3);
      if ($urandom_range(0, 29) == 0)
        redirect(32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC);
      else if ($urandom_range(0, 99) == 0)
        redirect(32'h0000_0202);
      else
        cyc();
    end
    id_ready = 1'b1; imem_req_ready = 1'b1;
    redirect(32'h400);
    for (int i = 0; i < 20; i++) cyc();
  endtask

  initial begin
    imem_req_ready = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge clk);
    test_reset();
    test_decode_stall();
    test_redirect_inflight();
    test_misaligned();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
